// File: rtl/pipe_stage_chain_pkg.sv
// Shared definitions for the EX/MEM pipeline register chain: default bundle widths,
// control-bundle field positions, slot operation codes and the counter-width helper.
package pipe_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int CTRL_W_DEF = 6;

   // Control bundle layout: MEM[3:0] in the low nibble, WB[1:0] above it.
   localparam int CTRL_MEM_LSB = 0;
   localparam int CTRL_MEM_W   = 4;
   localparam int CTRL_WB_LSB  = 4;
   localparam int CTRL_WB_W    = 2;

   typedef struct packed {
      logic [CTRL_WB_W-1:0]  wb;
      logic [CTRL_MEM_W-1:0] mem;
   } ctrl_t;

   typedef enum logic [1:0] {
      SLOT_HOLD   = 2'd0,
      SLOT_LOAD   = 2'd1,
      SLOT_BUBBLE = 2'd2,
      SLOT_FLUSH  = 2'd3
   } slot_op_e;

   // Width able to hold values 0..n-1, never narrower than one bit.
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/pipe_stage_chain_if.sv
// Upstream/downstream handshake bundle of the pipeline register chain.
// The master drives entries in and accepts them out; the slave is the chain itself.
interface pipe_stage_chain_if
   import pipe_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int CTRL_W = CTRL_W_DEF,
   parameter int CNT_W  = 2
);

   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic [CTRL_W-1:0] in_ctrl;

   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [CTRL_W-1:0] out_ctrl;

   logic [CNT_W-1:0]  occupancy;

   modport master (
      output in_valid, in_data, in_ctrl, out_ready,
      input  in_ready, out_valid, out_data, out_ctrl, occupancy
   );

   modport slave (
      input  in_valid, in_data, in_ctrl, out_ready,
      output in_ready, out_valid, out_data, out_ctrl, occupancy
   );

endinterface

// File: rtl/pipe_stage_chain_slot.sv
// One register slot of the chain: loads a valid entry, takes a bubble (ctrl cleared,
// data kept), holds on stall, or is killed by flush (valid/ctrl cleared, data kept).
module pipe_slot
   import pipe_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int CTRL_W = CTRL_W_DEF
)
(
   input  logic              clk,
   input  logic              reset,
   input  logic              flush_i,
   input  logic              advance_i,
   input  logic              up_valid_i,
   input  logic [DATA_W-1:0] up_data_i,
   input  logic [CTRL_W-1:0] up_ctrl_i,
   output logic              valid_o,
   output logic [DATA_W-1:0] data_o,
   output logic [CTRL_W-1:0] ctrl_o
);

   slot_op_e          op;
   logic              valid_q, valid_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [CTRL_W-1:0] ctrl_q, ctrl_d;

   always_comb begin
      op = SLOT_HOLD;
      if (flush_i) begin
         op = SLOT_FLUSH;
      end else if (advance_i) begin
         op = up_valid_i ? SLOT_LOAD : SLOT_BUBBLE;
      end
   end

   // Upstream ctrl is only sampled for a valid entry, so an undriven bus never leaks in.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      ctrl_d  = ctrl_q;
      case (op)
         SLOT_LOAD: begin
            valid_d = 1'b1;
            data_d  = up_data_i;
            ctrl_d  = up_ctrl_i;
         end
         SLOT_BUBBLE, SLOT_FLUSH: begin
            valid_d = 1'b0;
            ctrl_d  = '0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         ctrl_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         ctrl_q  <= ctrl_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;
   assign ctrl_o  = ctrl_q;

endmodule

// File: rtl/pipe_stage_chain.sv
// EX/MEM pipeline register chain: STAGES slots with valid/ready handshake, bubble
// collapse, combinational stall back-propagation, flush and an occupancy counter.
module pipe_stage_chain
   import pipe_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int CTRL_W = CTRL_W_DEF,
   parameter int STAGES = 2
)
(
   input  logic clk,
   input  logic reset,
   input  logic flush,
   pipe_stage_chain_if.slave bus
);

   localparam int CNT_W = clog2_min1(STAGES + 1);
   localparam int LAST  = (STAGES > 0) ? STAGES - 1 : 0;

   if (STAGES < 1) begin : g_bad_stages
      $error("pipe_stage_chain: STAGES must be at least 1");
   end

   logic [LAST:0]     slot_valid;
   logic [LAST:0]     rdy;
   logic [DATA_W-1:0] slot_data [LAST+1];
   logic [CTRL_W-1:0] slot_ctrl [LAST+1];

   for (genvar gi = 0; gi < STAGES; gi++) begin : g_slot
      logic              up_valid;
      logic [DATA_W-1:0] up_data;
      logic [CTRL_W-1:0] up_ctrl;

      if (gi == 0) begin : g_head
         assign up_valid = bus.in_valid;
         assign up_data  = bus.in_data;
         assign up_ctrl  = bus.in_ctrl;
      end else begin : g_body
         assign up_valid = slot_valid[gi-1];
         assign up_data  = slot_data[gi-1];
         assign up_ctrl  = slot_ctrl[gi-1];
      end

      // Unrolled ready chain: a slot may advance unless it and every slot after it are
      // occupied while the output is stalled.
      assign rdy[gi] = bus.out_ready | ~(&slot_valid[LAST:gi]);

      pipe_slot #(
         .DATA_W (DATA_W),
         .CTRL_W (CTRL_W)
      ) u_slot (
         .clk        (clk),
         .reset      (reset),
         .flush_i    (flush),
         .advance_i  (rdy[gi]),
         .up_valid_i (up_valid),
         .up_data_i  (up_data),
         .up_ctrl_i  (up_ctrl),
         .valid_o    (slot_valid[gi]),
         .data_o     (slot_data[gi]),
         .ctrl_o     (slot_ctrl[gi])
      );
   end

   logic             in_fire;
   logic             out_fire;
   logic [CNT_W-1:0] occ_q, occ_d;

   assign in_fire  = bus.in_valid & rdy[0];
   assign out_fire = slot_valid[LAST] & bus.out_ready;

   always_comb begin
      occ_d = occ_q + CNT_W'(in_fire) - CNT_W'(out_fire);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         occ_q <= '0;
      end else if (flush) begin
         occ_q <= '0;
      end else begin
         occ_q <= occ_d;
      end
      if (!reset && !flush) begin
         assert (!(in_fire && !out_fire && occ_q == CNT_W'(STAGES)));
         assert (!(out_fire && !in_fire && occ_q == '0));
      end
   end

   assign bus.in_ready  = rdy[0];
   assign bus.out_valid = slot_valid[LAST];
   assign bus.out_data  = slot_data[LAST];
   assign bus.out_ctrl  = slot_ctrl[LAST];
   assign bus.occupancy = occ_q;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Bench for pipe_stage_chain: directed scenarios on a 2-slot chain plus a random run on
// 1-, 2- and 4-slot chains sharing one stimulus, each tracked by an ordered entry queue.
module tb_pipe_stage_chain;
   import pipe_pkg::*;

   localparam int DW  = 32;
   localparam int CW  = 6;
   localparam int ST0 = 2;
   localparam int ST1 = 1;
   localparam int ST2 = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          flush = 1'b0;
   logic          in_valid = 1'b0;
   logic          out_ready = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic [CW-1:0] in_ctrl = '0;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   pipe_stage_chain_if #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(clog2_min1(ST0 + 1))) bus0 ();
   pipe_stage_chain_if #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(clog2_min1(ST1 + 1))) bus1 ();
   pipe_stage_chain_if #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(clog2_min1(ST2 + 1))) bus2 ();

   assign bus0.in_valid = in_valid;  assign bus0.in_data = in_data;
   assign bus0.in_ctrl  = in_ctrl;   assign bus0.out_ready = out_ready;
   assign bus1.in_valid = in_valid;  assign bus1.in_data = in_data;
   assign bus1.in_ctrl  = in_ctrl;   assign bus1.out_ready = out_ready;
   assign bus2.in_valid = in_valid;  assign bus2.in_data = in_data;
   assign bus2.in_ctrl  = in_ctrl;   assign bus2.out_ready = out_ready;

   pipe_stage_chain #(.DATA_W(DW), .CTRL_W(CW), .STAGES(ST0)) u_dut0 (
      .clk(clk), .reset(reset), .flush(flush), .bus(bus0));
   pipe_stage_chain #(.DATA_W(DW), .CTRL_W(CW), .STAGES(ST1)) u_dut1 (
      .clk(clk), .reset(reset), .flush(flush), .bus(bus1));
   pipe_stage_chain #(.DATA_W(DW), .CTRL_W(CW), .STAGES(ST2)) u_dut2 (
      .clk(clk), .reset(reset), .flush(flush), .bus(bus2));

   logic          rdy_a [3];
   logic          ov_a  [3];
   logic [DW-1:0] od_a  [3];
   logic [CW-1:0] oc_a  [3];
   int            occ_a [3];

   assign rdy_a[0] = bus0.in_ready;  assign ov_a[0] = bus0.out_valid;
   assign od_a[0]  = bus0.out_data;  assign oc_a[0] = bus0.out_ctrl;
   assign occ_a[0] = int'(bus0.occupancy);
   assign rdy_a[1] = bus1.in_ready;  assign ov_a[1] = bus1.out_valid;
   assign od_a[1]  = bus1.out_data;  assign oc_a[1] = bus1.out_ctrl;
   assign occ_a[1] = int'(bus1.occupancy);
   assign rdy_a[2] = bus2.in_ready;  assign ov_a[2] = bus2.out_valid;
   assign od_a[2]  = bus2.out_data;  assign oc_a[2] = bus2.out_ctrl;
   assign occ_a[2] = int'(bus2.occupancy);

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int st_of(input int k);
      return (k == 0) ? ST0 : (k == 1) ? ST1 : ST2;
   endfunction

   // Reference model: per chain, an ordered list of accepted entries with accept cycle.
   logic [DW-1:0] md [3][8];
   logic [CW-1:0] mc [3][8];
   int            ma [3][8];
   int            mhead [3];
   int            mcnt  [3];
   int            cyc = 0;
   int            last_stall = -1;
   bit            model_ok = 1'b0;

   always @(negedge clk) begin
      int  s;
      int  h;
      int  t;
      bit  in_fire;
      bit  out_fire;
      for (int k = 0; k < 3; k++) begin
         s        = st_of(k);
         h        = mhead[k];
         in_fire  = in_valid & rdy_a[k];
         out_fire = ov_a[k] & out_ready;
         if (model_ok) begin
            check_eq($sformatf("d%0d_occupancy", k), 64'(occ_a[k]), 64'(mcnt[k]));
            check_eq($sformatf("d%0d_in_ready", k), 64'(rdy_a[k]),
                     64'(!(mcnt[k] == s && !out_ready)));
            if (!ov_a[k]) check_eq($sformatf("d%0d_ctrl_invariant", k), 64'(oc_a[k]), 64'(0));
            if (mcnt[k] == 0) check_eq($sformatf("d%0d_valid_when_empty", k), 64'(ov_a[k]), 64'(0));
            if (mcnt[k] > 0 && ma[k][h] > last_stall && cyc == ma[k][h] + s)
               check_eq($sformatf("d%0d_arrival", k), 64'(ov_a[k]), 64'(1));
            if (out_fire && !reset && mcnt[k] > 0) begin
               check_eq($sformatf("d%0d_out_data", k), 64'(od_a[k]), 64'(md[k][h]));
               check_eq($sformatf("d%0d_out_ctrl", k), 64'(oc_a[k]), 64'(mc[k][h]));
               if (ma[k][h] > last_stall)
                  check_eq($sformatf("d%0d_latency", k), 64'(cyc - ma[k][h]), 64'(s));
            end
         end
         if (reset || flush) begin
            mhead[k] = 0;
            mcnt[k]  = 0;
         end else begin
            if (out_fire && mcnt[k] > 0) begin
               mhead[k] = (mhead[k] + 1) % 8;
               mcnt[k]--;
            end
            if (in_fire) begin
               t = (mhead[k] + mcnt[k]) % 8;
               md[k][t] = in_data;
               mc[k][t] = in_ctrl;
               ma[k][t] = cyc;
               mcnt[k]++;
            end
         end
      end
      if (reset) model_ok = 1'b1;
      if (!out_ready) last_stall = cyc;
      cyc++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [DW-1:0] d, input logic [CW-1:0] c);
      in_valid = 1'b1;
      in_data  = d;
      in_ctrl  = c;
      tick();
   endtask

   initial begin
      // Reset held two cycles under random inputs.
      for (int i = 0; i < 2; i++) begin
         reset = 1'b1;
         flush = 1'($urandom);  in_valid = 1'($urandom);  out_ready = 1'($urandom);
         in_data = $urandom;    in_ctrl = CW'($urandom);
         tick();
      end
      reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      #1;
      check_eq("reset_out_valid", bus0.out_valid, 0);
      check_eq("reset_out_ctrl", bus0.out_ctrl, 0);
      check_eq("reset_out_data", bus0.out_data, 0);
      check_eq("reset_occupancy", bus0.occupancy, 0);
      check_eq("reset_in_ready", bus0.in_ready, 1);

      // Streaming: one entry per cycle, each emerges two edges later.
      for (int k = 0; k < 5; k++) begin
         in_valid = (k < 3);
         in_data  = 32'h10 + k;
         in_ctrl  = 6'h2A;
         tick();
         if (k >= 1 && k <= 3) begin
            check_eq($sformatf("stream_valid_%0d", k), bus0.out_valid, 1);
            check_eq($sformatf("stream_data_%0d", k), bus0.out_data, 32'h10 + k - 1);
            check_eq($sformatf("stream_ctrl_%0d", k), bus0.out_ctrl, 6'h2A);
         end
         if (k == 2) check_eq("stream_occupancy", bus0.occupancy, 2);
         if (k == 4) begin
            check_eq("stream_drained_valid", bus0.out_valid, 0);
            check_eq("stream_drained_ctrl", bus0.out_ctrl, 0);
         end
      end

      // Backpressure: fill to two, stall, then release.
      out_ready = 1'b0;
      push(32'hA0, 6'h15);
      push(32'hA1, 6'h15);
      in_data = 32'hA2;
      #1;
      check_eq("bp_in_ready_full", bus0.in_ready, 0);
      check_eq("bp_occupancy_full", bus0.occupancy, 2);
      tick(); tick();
      check_eq("bp_hold_data", bus0.out_data, 32'hA0);
      out_ready = 1'b1;
      #1;
      check_eq("bp_release_in_ready", bus0.in_ready, 1);
      check_eq("bp_first_out", bus0.out_data, 32'hA0);
      tick();
      in_valid = 1'b0;
      check_eq("bp_second_out", bus0.out_data, 32'hA1);
      tick();
      check_eq("bp_third_valid", bus0.out_valid, 1);
      check_eq("bp_third_out", bus0.out_data, 32'hA2);
      tick();
      check_eq("bp_empty_valid", bus0.out_valid, 0);
      check_eq("bp_empty_occupancy", bus0.occupancy, 0);

      // Flush with both slots occupied while a new entry is handed over and dropped.
      out_ready = 1'b0;
      push(32'hB0, 6'h3F);
      push(32'hB1, 6'h3F);
      in_data = 32'hB2; flush = 1'b1; out_ready = 1'b1;
      #1;
      check_eq("flush_in_ready", bus0.in_ready, 1);
      tick();
      flush = 1'b0; in_valid = 1'b0;
      check_eq("flush_out_valid", bus0.out_valid, 0);
      check_eq("flush_out_ctrl", bus0.out_ctrl, 0);
      // The output slot keeps whatever data it held when it was killed.
      check_eq("flush_data_held", bus0.out_data, 32'hB0);
      check_eq("flush_occupancy", bus0.occupancy, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check_eq($sformatf("flush_no_b2_%0d", i), bus0.out_valid, 0);
      end

      // Reset and flush together on a full, stalled pipe.
      out_ready = 1'b0;
      push(32'hC0, 6'h21);
      push(32'hC1, 6'h22);
      in_data = 32'hC2; reset = 1'b1; flush = 1'b1;
      tick();
      reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
      #1;
      check_eq("rstfl_out_valid", bus0.out_valid, 0);
      check_eq("rstfl_out_data", bus0.out_data, 0);
      check_eq("rstfl_out_ctrl", bus0.out_ctrl, 0);
      check_eq("rstfl_occupancy", bus0.occupancy, 0);
      check_eq("rstfl_in_ready", bus0.in_ready, 1);
      out_ready = 1'b1;
      push(32'hD0, 6'h0C);
      in_valid = 1'b0;
      check_eq("rstfl_lat_1", bus0.out_valid, 0);
      tick();
      check_eq("rstfl_lat_2_valid", bus0.out_valid, 1);
      check_eq("rstfl_lat_2_data", bus0.out_data, 32'hD0);
      check_eq("rstfl_lat_2_ctrl", bus0.out_ctrl, 6'h0C);

      // Random traffic on all three chains, alternating stall-free and stalled windows.
      for (int i = 0; i < 10000; i++) begin
         in_valid  = ($urandom_range(3) != 0);
         in_data   = 32'h1000_0000 + i;
         in_ctrl   = CW'($urandom);
         out_ready = ((i / 256) % 2 == 1) ? 1'b1 : ($urandom_range(2) != 0);
         flush     = ($urandom_range(127) == 0);
         tick();
      end
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 8; i++) tick();
      check_eq("final_drain_d0", bus0.occupancy, 0);
      check_eq("final_drain_d2", bus2.occupancy, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
